// File: rtl/posit_pkg.sv
// posit_pkg: shared definitions for the posit32 (es=3) encoder/decoder pair.
// Holds format widths, FSM state encoding, special-value constants and the
// regime length helper.
package posit_pkg;

  localparam int N      = 32;          // posit width
  localparam int ES     = 3;           // exponent field width
  localparam int BODY_W = N - 1;       // magnitude body below the sign bit
  localparam int TAIL_W = ES + N - 1;  // {exp, fraction} stream after the regime

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BUILD = 3'd1,
    ST_ROUND = 3'd2,
    ST_PACK  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [N-1:0] MAXPOS = 32'h7FFF_FFFF;
  localparam logic [N-1:0] MINPOS = 32'h0000_0001;
  localparam logic [N-1:0] NAR    = 32'h8000_0000;

  localparam int K_MAX = 30;   // k at or above this saturates to maxpos
  localparam int K_MIN = -31;  // k at or below this saturates to minpos

  // Total regime length including the terminating bit:
  // k>=0 -> k+2, k<0 -> -k+1 (== ~k + 2 in two's complement).
  function automatic logic [5:0] regime_len(input logic [5:0] k);
    return k[5] ? (~k + 6'd2) : (k + 6'd2);
  endfunction

endpackage

// File: rtl/posit_rne_round.sv
// posit_rne_round: round-to-nearest-even on the 31-bit posit body.
//   body    - unrounded body bits
//   guard   - first stream bit below the body LSB
//   sticky  - OR of every stream bit below guard
//   rounded - rounded body; never increments past all-ones (maxpos)
module posit_rne_round (
  input  logic [30:0] body,
  input  logic        guard,
  input  logic        sticky,
  output logic [30:0] rounded
);

  logic round_up;

  // Ties go to even; an all-ones body is already maxpos and must not wrap.
  assign round_up = guard & (sticky | body[0]) & ~(&body);
  assign rounded  = body + {30'd0, round_up};

endmodule

// File: rtl/posit_encoder.sv
// posit_encoder: sequential posit32 (es=3) packer.
//   clk, rst        - clock and asynchronous active-high reset
//   start           - request, sampled only while idle
//   in_sign, in_k, in_exp, in_mant, in_zero, in_nar - decoded value fields
//   posit_out       - encoded posit, held until the next accepted start
//   busy            - high in BUILD, ROUND and PACK
//   done            - one-cycle pulse when posit_out is valid
//
// state | meaning
// IDLE  | wait for start, latch fields, detect special values
// BUILD | shift 31 stream bits (regime, exponent, fraction) into the body
// ROUND | round body to nearest even using guard/sticky left in the tail
// PACK  | apply sign / special value and register posit_out
// DONE  | done pulse, back to IDLE
module posit_encoder
  import posit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_sign,
  input  logic [5:0]    in_k,
  input  logic [ES-1:0] in_exp,
  input  logic [N-1:0]  in_mant,
  input  logic          in_zero,
  input  logic          in_nar,
  output logic [N-1:0]  posit_out,
  output logic          busy,
  output logic          done
);

  localparam logic signed [5:0] K_HI = 6'(K_MAX);
  localparam logic signed [5:0] K_LO = 6'(K_MIN);

  state_t state_q, state_d;

  logic              sign_q, nar_q, zero_q, neg_q;
  logic [5:0]        reg_cnt_q;
  logic [4:0]        bit_cnt_q;
  logic [TAIL_W-1:0] tail_q;
  logic [BODY_W-1:0] body_q;

  logic              sat_hi, sat_lo, special;
  logic              stream_bit;
  logic [BODY_W-1:0] body_rnd;
  logic [N-1:0]      mag, word;

  // The hidden bit is implied by the encoding and never enters the stream.
  logic unused_hidden;
  assign unused_hidden = in_mant[N-1];

  assign sat_hi  = $signed(in_k) >= K_HI;
  assign sat_lo  = $signed(in_k) <= K_LO;
  assign special = in_nar | in_zero | sat_hi | sat_lo;

  // Regime run bits while the counter is above one, the terminator at one,
  // then the tail MSB once the regime is exhausted.
  always_comb begin
    if (reg_cnt_q == 6'd0)      stream_bit = tail_q[TAIL_W-1];
    else if (reg_cnt_q == 6'd1) stream_bit = neg_q;
    else                        stream_bit = ~neg_q;
  end

  // In range the regime fits in 31 bits, so after BUILD the unconsumed tail
  // holds exactly the guard bit and the sticky bits (zero-filled below).
  posit_rne_round u_round (
    .body    (body_q),
    .guard   (tail_q[TAIL_W-1]),
    .sticky  (|tail_q[TAIL_W-2:0]),
    .rounded (body_rnd)
  );

  assign mag = {1'b0, body_q};

  always_comb begin
    word = mag;
    if (nar_q)       word = NAR;
    else if (zero_q) word = '0;
    else if (sign_q) word = ~mag + 32'd1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = special ? ST_PACK : ST_BUILD;
      ST_BUILD: if (bit_cnt_q == 5'd0) state_d = ST_ROUND;
      ST_ROUND: state_d = ST_PACK;
      ST_PACK:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q    <= 1'b0;
      nar_q     <= 1'b0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      reg_cnt_q <= '0;
      bit_cnt_q <= '0;
      tail_q    <= '0;
      body_q    <= '0;
      posit_out <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            sign_q    <= in_sign;
            nar_q     <= in_nar;
            zero_q    <= in_zero;
            neg_q     <= in_k[5];
            reg_cnt_q <= regime_len(in_k);
            bit_cnt_q <= 5'd30;
            tail_q    <= {in_exp, in_mant[N-2:0]};
            if (sat_hi)      body_q <= MAXPOS[BODY_W-1:0];
            else if (sat_lo) body_q <= MINPOS[BODY_W-1:0];
            else             body_q <= '0;
          end
        end
        ST_BUILD: begin
          body_q <= {body_q[BODY_W-2:0], stream_bit};
          if (reg_cnt_q != 6'd0) reg_cnt_q <= reg_cnt_q - 6'd1;
          else                   tail_q    <= {tail_q[TAIL_W-2:0], 1'b0};
          if (bit_cnt_q != 5'd0) bit_cnt_q <= bit_cnt_q - 5'd1;
        end
        ST_ROUND: body_q    <= body_rnd;
        ST_PACK:  posit_out <= word;
        default: ;
      endcase
    end
  end

  assign busy = (state_q == ST_BUILD) || (state_q == ST_ROUND) || (state_q == ST_PACK);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_posit_encoder.sv
// tb_posit_encoder: scoreboard bench for posit_encoder. The driver pushes the
// expected word and latency for every accepted request; a monitor pops and
// compares on each done pulse. Random operands are checked against a
// bit-stream reference model built from the posit encoding rules.
module tb_posit_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_sign = 1'b0;
  logic [5:0]  in_k = '0;
  logic [2:0]  in_exp = '0;
  logic [31:0] in_mant = '0;
  logic        in_zero = 1'b0;
  logic        in_nar = 1'b0;
  logic [31:0] posit_out;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] word;
    int          t0;
    int          lat;
    int          id;
  } exp_t;

  exp_t sb[$];

  posit_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_sign   (in_sign),
    .in_k      (in_k),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .posit_out (posit_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: spell out the bit stream, cut 31 body bits, round by value.
  function automatic logic [31:0] ref_encode(input logic s, input logic [5:0] k6,
                                             input logic [2:0] e, input logic [31:0] m,
                                             input logic z, input logic n);
    bit     q[$];
    longint v;
    bit     guard, sticky;
    int     k;
    k = $signed(k6);
    if (n) return 32'h8000_0000;
    if (z) return 32'h0000_0000;
    v = 0;
    if (k >= 30) v = 64'h7FFF_FFFF;
    else if (k <= -31) v = 1;
    else begin
      if (k >= 0) begin
        for (int i = 0; i < k + 1; i++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int i = 2; i >= 0; i--) q.push_back(e[i]);
      for (int i = 30; i >= 0; i--) q.push_back(m[i]);
      for (int i = 0; i < 31; i++) v = v * 2 + longint'(q[i]);
      guard = q[31];
      sticky = 1'b0;
      for (int i = 32; i < q.size(); i++) sticky = sticky | q[i];
      if (guard && (sticky || (v % 2 == 1)) && v != 64'h7FFF_FFFF) v = v + 1;
    end
    if (s) v = 64'h1_0000_0000 - v;
    return v[31:0];
  endfunction

  function automatic bit is_special(input logic [5:0] k6, input logic z, input logic n);
    int k;
    k = $signed(k6);
    return n || z || k >= 30 || k <= -31;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done with no pending request, posit_out=%h required no done", posit_out);
      end else begin
        exp_t x;
        x = sb.pop_front();
        if (posit_out !== x.word) begin
          errors++;
          $display("FAIL op%0d_value: got %h required %h", x.id, posit_out, x.word);
        end
        checks++;
        if (cyc - x.t0 + 1 != x.lat) begin
          errors++;
          $display("FAIL op%0d_latency: got %0d edges required %0d", x.id, cyc - x.t0 + 1, x.lat);
        end
      end
    end
  end

  // Drive one request; returns at the negedge after the sampling edge.
  task automatic issue(input logic s, input logic [5:0] k, input logic [2:0] e,
                       input logic [31:0] m, input logic z, input logic n,
                       input logic [31:0] expw, input bit track, input int id);
    exp_t x;
    @(negedge clk);
    in_sign = s; in_k = k; in_exp = e; in_mant = m; in_zero = z; in_nar = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (track) begin
      x.word = expw;
      x.t0   = cyc;
      x.lat  = is_special(k, z, n) ? 2 : 34;
      x.id   = id;
      sb.push_back(x);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL op%0d_busy: got %b required 1", id, busy);
    end
  endtask

  task automatic wait_done(input int id);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL op%0d_timeout: done=%b after %0d cycles required 1", id, done, n);
    end
  endtask

  task automatic run(input logic s, input logic [5:0] k, input logic [2:0] e,
                     input logic [31:0] m, input logic z, input logic n,
                     input logic [31:0] expw, input int id);
    issue(s, k, e, m, z, n, expw, 1'b1, id);
    wait_done(id);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s, z, n;
    logic [5:0]  k;
    logic [2:0]  e;
    logic [31:0] m;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (posit_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got out=%h busy=%b done=%b required 0/0/0", posit_out, busy, done);
    end
    rst = 1'b0;

    run(1'b0, 6'd0,    3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'h4000_0000, 1);
    run(1'b1, 6'd0,    3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'hC000_0000, 2);
    run(1'b0, 6'h3F,   3'd5, 32'hC000_0000, 1'b0, 1'b0, 32'h3600_0000, 3);
    run(1'b0, 6'd29,   3'd4, 32'h8000_0000, 1'b0, 1'b0, 32'h7FFF_FFFE, 4);
    run(1'b0, 6'd29,   3'd5, 32'h8000_0000, 1'b0, 1'b0, 32'h7FFF_FFFF, 5);
    run(1'b0, 6'd30,   3'd2, 32'hABCD_1234, 1'b0, 1'b0, 32'h7FFF_FFFF, 6);
    run(1'b0, 6'h21,   3'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0001, 7);
    run(1'b1, 6'h21,   3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 8);
    run(1'b0, 6'd3,    3'd1, 32'h9000_0000, 1'b1, 1'b1, 32'h8000_0000, 9);
    run(1'b1, 6'd3,    3'd1, 32'h9000_0000, 1'b1, 1'b0, 32'h0000_0000, 10);

    // Second start while busy must be dropped.
    issue(1'b0, 6'h3F, 3'd5, 32'hC000_0000, 1'b0, 1'b0, 32'h3600_0000, 1'b1, 11);
    repeat (5) @(negedge clk);
    in_k = 6'h21; in_sign = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(11);
    repeat (40) @(negedge clk);

    // Abort in the 10th BUILD cycle; posit_out is nonzero beforehand.
    issue(1'b1, 6'd0, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b0, 12);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (posit_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: got out=%h busy=%b done=%b required 0/0/0", posit_out, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done: got done=%b required 0", done);
      end
    end
    rst = 1'b0;
    run(1'b0, 6'd0, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'h4000_0000, 13);

    for (int i = 0; i < 48; i++) begin
      s = 1'($urandom_range(0, 1));
      k = 6'($urandom_range(0, 63));
      e = 3'($urandom_range(0, 7));
      m = {1'b1, 31'($urandom)};
      z = ($urandom_range(0, 19) == 0);
      n = ($urandom_range(0, 19) == 0);
      run(s, k, e, m, z, n, ref_encode(s, k, e, m, z, n), 100 + i);
    end

    repeat (40) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_ops: got %0d outstanding required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/posit_encoder.md
Name: posit_encoder

Overview:
Sequential posit32 (es=3) encoder. It is the packing stage that pairs with posit_decoder: it takes the same field format the decoder produces and emits a 32-bit posit.
- Input fields: sign, regime run value k, 3-bit exponent, 32-bit mantissa with the hidden 1 at bit 31.
- Sits at the output of the posit datapath, so arithmetic units work on decoded fields and re-encode through this block.
- Builds the body serially, one bit per cycle, then rounds to nearest even, saturates and applies two's complement for negatives.

Parameters:
- N, 32, posit width (fixed; only 32 is supported).
- ES, 3, exponent field width (fixed; must match the decoder).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- in_sign  input  1  sign of the value.
- in_k  input  6  signed regime value; same encoding as the decoder's k output.
- in_exp  input  3  exponent field.
- in_mant  input  32  mantissa; bit 31 is the hidden 1, bits 30:0 are the fraction.
- in_zero  input  1  value is zero; overrides all other fields.
- in_nar  input  1  value is NaR; overrides in_zero and all other fields.
- posit_out  output  32  encoded posit; held stable until the next accepted start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when posit_out becomes valid.

Behaviour:
- Reset (async): state=IDLE; posit_out=0, busy=0, done=0; all internal registers cleared. Reset mid-operation aborts; no done is issued.
- Value encoded: (-1)^s * 2^(8k+e) * 1.f.
- Regime bits:
  - k>=0: (k+1) ones followed by a 0.
  - k<0: (-k) zeros followed by a 1.
- Bit stream, MSB first: regime bits, then in_exp[2:0], then in_mant[30:0].
- States: IDLE -> BUILD -> ROUND -> PACK -> DONE -> IDLE.
  - A special case goes IDLE -> PACK -> DONE.
  - done=1 only in DONE.
  - busy=1 in BUILD, ROUND and PACK.
- IDLE:
  - On start=1, latch all inputs.
  - Special cases take priority in this order: NaR, zero, k>=30 (body=0x7FFFFFFF, maxpos), k<=-31 (body=0x00000001, minpos).
  - Otherwise load the regime counter and the 34-bit tail {exp, mant[30:0]}, then go to BUILD.
  - start while not in IDLE is ignored, not queued.
- BUILD: exactly 31 cycles. Each cycle shifts one stream bit into the 31-bit body LSB: regime bits first (counter-driven), then tail bits MSB first.
- Guard and sticky after the 31st body bit:
  - guard = next stream bit.
  - sticky = OR of all remaining stream bits.
  - For -30<=k<=29 the regime always fits in 31 bits, so guard and sticky come from the tail only.
- ROUND (round to nearest even):
  - Round up when guard & (sticky | body[0]).
  - Never round past 0x7FFFFFFF; the increment is suppressed when body is all ones.
  - Never round to zero; this holds structurally because the body is always nonzero.
- PACK:
  - Word = {0, body}; if sign=1, word = two's complement of the word.
  - NaR gives 0x80000000; zero gives 0x00000000, with sign ignored for both.
  - The word is registered into posit_out.
- DONE: done=1 for one cycle; then IDLE.
- Latency, measured from the edge that samples start to the cycle where done is high:
  - Normal path: 34 edges.
  - Special cases: 2 edges.
- A new start may be sampled on the cycle after DONE.

Decomposition:
- Package posit_pkg: N=32, ES=3, state encodings, and constants MAXPOS=0x7FFFFFFF, MINPOS=0x00000001, NAR=0x80000000, K_MAX=30, K_MIN=-31. The package is shared with posit_decoder.
- One combinational sub-module, posit_rne_round.
  - Inputs: body[30:0], guard, sticky.
  - Output: rounded body, with saturation at all-ones.
- The FSM, regime counter and shift registers stay in posit_encoder.

Test Plan:
1. sign=0, k=0, exp=0, mant=0x80000000 -> posit_out=0x40000000; done exactly 34 edges after start.
2. Same fields with sign=1 -> 0xC0000000. Also k=-1, exp=5, mant=0xC0000000 -> 0x36000000.
3. Rounding: k=29, exp=4, mant=0x80000000 is a tie with even LSB -> 0x7FFFFFFE. k=29, exp=5 has sticky set -> 0x7FFFFFFF.
4. Saturation, with done 2 edges after start:
   - k=30, any exp/mant -> 0x7FFFFFFF.
   - k=-31 -> 0x00000001.
   - k=-31 with sign=1 -> 0xFFFFFFFF.
5. in_nar=1 with in_zero=1 -> 0x80000000. in_zero=1 with sign=1 -> 0x00000000. A second start pulsed while busy is ignored: exactly one done, and the result comes from the first operand.
6. Assert rst in the 10th BUILD cycle -> posit_out=0, busy=0, done stays 0. A start after reset release encodes correctly (repeat scenario 1).
